uart_rx_ctrl: RTL

Receive-side controller that sequences `uart_sampler`. It generates the mid-bit `tick` strobes from the sampler's `align` pulse, assembles the sampled bits LSB-first into bytes, and buffers completed frames in a first-word-fall-through FIFO with a valid/ready output. It sits between `uart_sampler` and the byte consumer, and also keeps the receive status: a framing-error count and an overrun flag.

---
 rtl/uart_rx_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: baud tick generation, byte assembly and FWFT byte FIFO behind uart_sampler
module uart_rx_ctrl #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_align,
  input  logic                          s_busy,
  input  logic                          s_bit_valid,
  input  logic                          s_bit_data,
  input  logic                          s_frame_done,
  input  logic                          s_framing_error,
  output logic                          tick,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  input  logic                          clr_status,
  output logic                          overrun,
  output logic [7:0]                    frame_err_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int DIV  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          pop, push, full, good;

  // Baud timer: align reloads half a bit so ticks land mid-bit, then one tick per DIV while busy
  always_comb begin
    tick_d = !s_align && s_busy && (cnt_q == '0);
    cnt_d  = s_align ? CW'(HALF - 1) : !s_busy ? cnt_q : tick_d ? CW'(DIV - 1) : cnt_q - 1'b1;
  end

  // Byte assembly LSB-first, plus frame commit, FIFO bookkeeping and status next-state
  always_comb begin
    shreg_d  = s_bit_valid ? {s_bit_data, shreg_q[7:1]} : shreg_q;
    bitcnt_d = s_align ? 4'd0 : s_bit_valid ? bitcnt_q + 4'd1 : bitcnt_q;
    pop      = m_valid & m_ready;
    full     = level_q == LW'(FIFO_DEPTH);
    good     = s_frame_done & ~s_framing_error & (bitcnt_q == 4'd8);
    push     = good & (~full | pop);
    wptr_d   = wptr_q + PW'(push);
    rptr_d   = rptr_q + PW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    ovr_d    = clr_status ? 1'b0 : ovr_q | (good & full & ~pop);
    err_d    = clr_status ? 8'd0 : err_q + {7'd0, s_frame_done & s_framing_error & (err_q != 8'hFF)};
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      ovr_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      ovr_q    <= ovr_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; contents need no reset because the level gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= shreg_q;
  end

  assign tick          = tick_q;
  assign m_valid       = level_q != '0;
  assign m_data        = m_valid ? mem[rptr_q] : 8'd0;
  assign overrun       = ovr_q;
  assign frame_err_cnt = err_q;
  assign fifo_level    = level_q;
endmodule
